pwm_frame_ctrl: RTL and testbench
=================================

// Module: pwm_frame_ctrl
// PURPOSE
//  Host-side controller for the 8-channel servo/ESC PWM generator. Accepts per-channel pulse
//  widths (us) over a valid/ready write port into a shadow bank and clamps them. Commits the bank
//  to the generator only on a 2.5 ms frame boundary, so a frame never mixes old and new widths.
//  Owns the generator enable and sequences DISARMED/ARMING/ARMED/FAILSAFE, with a link-loss timeout.
// PARAMETERS
//  CLK_PER_US   50     CLK cycles per 1 us tick; must match the generator prescale (49+1)
//  FRAME_US     2500   frame length in us; must match the generator period (2499+1)
//  MIN_US       1000   lower clamp for nonzero widths; also the ARMING output value
//  MAX_US       2000   upper clamp for widths
//  FS_US        1000   width driven on all channels in FAILSAFE
//  ARM_FRAMES   400    frames held at MIN_US in ARMING (1 s)
//  TIMEOUT_FR   40     frames without a Commit in ARMED before FAILSAFE (100 ms)
// PORTS
//  CLK          in   1   system clock, 50 MHz
//  RSTn         in   1   reset, asynchronous, active-low
//  Wr_Valid     in   1   host write request
//  Wr_Ready     out  1   write accepted when Wr_Valid & Wr_Ready at posedge
//  Wr_Ch        in   3   channel index 0..7
//  Wr_Data      in   16  pulse width in us; 0 = channel off
//  Commit       in   1   1-cycle pulse: transfer shadow bank at next frame boundary
//  Arm_Req      in   1   1-cycle pulse: request arming
//  Disarm_Req   in   1   1-cycle pulse: immediate disarm
//  Ch_W[0..7]   out  16  per-channel width to generator Channel1..8 (registered)
//  PWM_En       out  1   generator enable
//  State        out  2   00 DISARMED, 01 ARMING, 10 ARMED, 11 FAILSAFE
//  Frame_Tick   out  1   1-cycle pulse on the frame wrap cycle
// BEHAVIOUR
//  Reset: State=DISARMED, PWM_En=0, all Ch_W=0, shadow=0, active=0, pending=0, Wr_Ready=1, Frame_Tick=0.
//  Frame timer: prescaler 0..CLK_PER_US-1 plus us counter 0..FRAME_US-1. Both are held at 0 while
//   PWM_En=0, so the timer stays phase-locked to the generator. Frame_Tick=1 when both are at max.
//  Write: on accept, shadow[Wr_Ch] <= clamp(Wr_Data). Clamp: 0 -> 0; <MIN_US -> MIN_US; >MAX_US -> MAX_US.
//  Commit: sets pending. Wr_Ready=0 while pending. Commit while pending is ignored.
//   On Frame_Tick with pending: active <= shadow and pending <= 0 (Wr_Ready returns 1 next cycle).
//   If PWM_En=0 (no ticks), a pending commit transfers on the next cycle.
//  FSM, evaluated every cycle; Disarm_Req has priority over everything, including a simultaneous Arm_Req:
//   DISARMED: PWM_En=0, Ch_W=0. Arm_Req -> ARMING (frame counter cleared to 0).
//   ARMING:   PWM_En=1, Ch_W=MIN_US. After ARM_FRAMES Frame_Ticks -> ARMED.
//   ARMED:    Ch_W=active, loaded on Frame_Tick only. TIMEOUT_FR consecutive Frame_Ticks without
//             an accepted Commit -> FAILSAFE.
//   FAILSAFE: Ch_W=FS_US for nonzero active channels; 0 stays 0. An accepted Commit sets pending;
//             the transfer tick returns to ARMED with the new bank on that same tick.
//  Disarm_Req: next cycle State=DISARMED, PWM_En=0, Ch_W=0. Mid-frame truncation is intended (safety).
//  Ch_W changes only on Frame_Tick cycles, except on entry to DISARMED/ARMING (on the FSM transition).
//  Timeout counter: cleared on accepted Commit and on ARMED entry; saturates at TIMEOUT_FR.
//  Arm frame counter: cleared on ARMING entry; 9 bits.
//  Reset mid-frame: everything returns to reset values asynchronously; the generator sees En=0.
// STRUCTURE
//  Shared package pwm_pkg: state encodings, NUM_CH=8, width type (16 bit), clamp function.
//  Sub-module pwm_frame_timer (CLK_PER_US, FRAME_US): inputs En; output Frame_Tick.
//  Top holds the shadow/active banks, pending flag, FSM, and timeout/arm counters.
// TESTING
//  Reset, then write ch0=1500 and Commit while disarmed -> Ch_W stays 0, PWM_En=0, Wr_Ready low 1 cycle.
//  Arm_Req (ARM_FRAMES=4 in test) -> all Ch_W=1000 for 4 frames, then ARMED with ch0=1500.
//   Ch_W changes only on Frame_Tick.
//  In ARMED, write ch3=500, ch4=2600, ch5=0, then Commit mid-frame -> ch3=1000, ch4=2000, ch5=0.
//   Values appear on the next Frame_Tick. A write during pending is stalled (Wr_Ready=0).
//  No Commit for TIMEOUT_FR=3 frames -> State=11 with nonzero Ch_W=1000.
//   Then Commit -> ARMED on the next tick with the new values.
//  Disarm_Req and Arm_Req in the same cycle mid-frame -> DISARMED next cycle, PWM_En=0, Ch_W=0.
//  RSTn asserted mid-frame with a commit pending -> all outputs 0 immediately; pending lost.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types for the servo/ESC PWM frame controller: state encoding,
// channel bank layout and the pulse-width clamp.
package pwm_pkg;
  localparam int unsigned NUM_CH = 8;
  localparam int unsigned W_W    = 16;

  typedef logic [W_W-1:0]       width_t;
  typedef width_t [NUM_CH-1:0]  bank_t;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'b00,
    ST_ARMING   = 2'b01,
    ST_ARMED    = 2'b10,
    ST_FAILSAFE = 2'b11
  } state_t;

  // Zero means channel off and is never raised to the lower clamp.
  function automatic width_t clamp_us(input width_t w, input width_t lo, input width_t hi);
    width_t r;
    if (w == '0)     r = '0;
    else if (w < lo) r = lo;
    else if (w > hi) r = hi;
    else             r = w;
    return r;
  endfunction
endpackage

// File: rtl/pwm_frame_timer.sv
// Frame timer phase-locked to the PWM generator: us prescaler plus frame
// counter, both held at zero while the generator is disabled.
module pwm_frame_timer #(
  parameter int unsigned CLK_PER_US = 50,
  parameter int unsigned FRAME_US   = 2500
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic En,
  output logic Frame_Tick
);
  localparam int unsigned PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int unsigned UW = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
  localparam logic [PW-1:0] PSC_MAX = PW'(CLK_PER_US - 1);
  localparam logic [UW-1:0] US_MAX  = UW'(FRAME_US - 1);

  logic [PW-1:0] psc;
  logic [UW-1:0] us_cnt;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      psc    <= '0;
      us_cnt <= '0;
    end else if (!En) begin
      psc    <= '0;
      us_cnt <= '0;
    end else if (psc == PSC_MAX) begin
      psc    <= '0;
      us_cnt <= (us_cnt == US_MAX) ? '0 : us_cnt + 1'b1;
    end else begin
      psc <= psc + 1'b1;
    end
  end

  assign Frame_Tick = En && (psc == PSC_MAX) && (us_cnt == US_MAX);
endmodule

// File: rtl/pwm_frame_ctrl.sv
// Host-side controller for the 8-channel PWM generator: shadow/active width
// banks committed on frame boundaries, arming sequence and link-loss failsafe.
module pwm_frame_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_PER_US = 50,
  parameter int unsigned FRAME_US   = 2500,
  parameter int unsigned MIN_US     = 1000,
  parameter int unsigned MAX_US     = 2000,
  parameter int unsigned FS_US      = 1000,
  parameter int unsigned ARM_FRAMES = 400,
  parameter int unsigned TIMEOUT_FR = 40
) (
  input  logic                          CLK,
  input  logic                          RSTn,
  input  logic                          Wr_Valid,
  output logic                          Wr_Ready,
  input  logic [2:0]                    Wr_Ch,
  input  logic [W_W-1:0]                Wr_Data,
  input  logic                          Commit,
  input  logic                          Arm_Req,
  input  logic                          Disarm_Req,
  output logic [NUM_CH-1:0][W_W-1:0]    Ch_W,
  output logic                          PWM_En,
  output logic [1:0]                    State,
  output logic                          Frame_Tick
);
  localparam width_t MIN_W = width_t'(MIN_US);
  localparam width_t MAX_W = width_t'(MAX_US);
  localparam width_t FS_W  = width_t'(FS_US);
  localparam int unsigned TW = $clog2(TIMEOUT_FR + 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_FR);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_FR - 1);
  localparam logic [8:0]    ARM_LAST = 9'(ARM_FRAMES - 1);

  state_t        state;
  bank_t         shadow, active, active_nxt, fs_bank;
  logic          pending, wr_acc, commit_acc, transfer;
  logic [8:0]    arm_cnt;
  logic [TW-1:0] to_cnt;

  pwm_frame_timer #(
    .CLK_PER_US (CLK_PER_US),
    .FRAME_US   (FRAME_US)
  ) u_timer (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .En         (PWM_En),
    .Frame_Tick (Frame_Tick)
  );

  assign Wr_Ready   = !pending;
  assign wr_acc     = Wr_Valid && !pending;
  assign commit_acc = Commit && !pending;
  // With the generator stopped there are no ticks, so a pending bank moves at once.
  assign transfer   = pending && (Frame_Tick || !PWM_En);
  assign State      = state;

  always_comb begin
    active_nxt = transfer ? shadow : active;
    fs_bank    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      fs_bank[i] = (active_nxt[i] == '0) ? '0 : FS_W;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (wr_acc)
        shadow[Wr_Ch] <= clamp_us(Wr_Data, MIN_W, MAX_W);
      if (transfer) begin
        active  <= shadow;
        pending <= 1'b0;
      end else if (commit_acc) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= ST_DISARMED;
      PWM_En  <= 1'b0;
      Ch_W    <= '0;
      arm_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      if (commit_acc)
        to_cnt <= '0;
      else if (Frame_Tick && to_cnt != TO_MAX)
        to_cnt <= to_cnt + 1'b1;

      if (Disarm_Req) begin
        state  <= ST_DISARMED;
        PWM_En <= 1'b0;
        Ch_W   <= '0;
      end else begin
        case (state)
          ST_DISARMED: if (Arm_Req) begin
            state   <= ST_ARMING;
            PWM_En  <= 1'b1;
            Ch_W    <= {NUM_CH{MIN_W}};
            arm_cnt <= '0;
          end
          ST_ARMING: if (Frame_Tick) begin
            if (arm_cnt == ARM_LAST) begin
              state  <= ST_ARMED;
              Ch_W   <= active_nxt;
              to_cnt <= '0;
            end else begin
              arm_cnt <= arm_cnt + 1'b1;
            end
          end
          ST_ARMED: if (Frame_Tick) begin
            if (!commit_acc && to_cnt >= TO_LAST) begin
              state <= ST_FAILSAFE;
              Ch_W  <= fs_bank;
            end else begin
              Ch_W <= active_nxt;
            end
          end
          ST_FAILSAFE: if (Frame_Tick) begin
            if (transfer) begin
              state  <= ST_ARMED;
              Ch_W   <= active_nxt;
              to_cnt <= '0;
            end else begin
              Ch_W <= fs_bank;
            end
          end
          default: state <= ST_DISARMED;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pwm_frame_ctrl.sv
// Directed scoreboard bench for pwm_frame_ctrl with a shortened frame,
// ARM_FRAMES=4 and TIMEOUT_FR=3.
module tb_pwm_frame_ctrl;
  import pwm_pkg::*;

  localparam int unsigned CPU       = 2;
  localparam int unsigned FUS       = 10;
  localparam int unsigned ARMF      = 4;
  localparam int unsigned TOF       = 3;
  localparam int unsigned FRAME_CYC = CPU * FUS;

  logic CLK = 1'b0, RSTn = 1'b0;
  logic Wr_Valid = 1'b0, Commit = 1'b0, Arm_Req = 1'b0, Disarm_Req = 1'b0;
  logic [2:0]  Wr_Ch = '0;
  logic [15:0] Wr_Data = '0;
  logic        Wr_Ready, PWM_En, Frame_Tick;
  logic [1:0]  State;
  bank_t       Ch_W;

  always #5 CLK = ~CLK;

  pwm_frame_ctrl #(
    .CLK_PER_US (CPU),
    .FRAME_US   (FUS),
    .MIN_US     (1000),
    .MAX_US     (2000),
    .FS_US      (1000),
    .ARM_FRAMES (ARMF),
    .TIMEOUT_FR (TOF)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .Wr_Valid   (Wr_Valid),
    .Wr_Ready   (Wr_Ready),
    .Wr_Ch      (Wr_Ch),
    .Wr_Data    (Wr_Data),
    .Commit     (Commit),
    .Arm_Req    (Arm_Req),
    .Disarm_Req (Disarm_Req),
    .Ch_W       (Ch_W),
    .PWM_En     (PWM_En),
    .State      (State),
    .Frame_Tick (Frame_Tick)
  );

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic       en;
    logic       rdy;
    logic       ft;
    bank_t      chw;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic push(input string tag, input logic [1:0] st, input logic en,
                      input logic rdy, input logic ft, input bank_t chw);
    exp_t e;
    e.tag = tag; e.st = st; e.en = en; e.rdy = rdy; e.ft = ft; e.chw = chw;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    logic [132:0] obs, exv;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL sb_empty: got no expectation, required one queued");
    end else begin
      e   = sb.pop_front();
      obs = {State, PWM_En, Wr_Ready, Frame_Tick, Ch_W};
      exv = {e.st, e.en, e.rdy, e.ft, e.chw};
      assert (obs === exv) else begin
        miscompares++;
        $error("FAIL %s: got st=%b en=%b rdy=%b ft=%b chw=%h, expected st=%b en=%b rdy=%b ft=%b chw=%h",
               e.tag, State, PWM_En, Wr_Ready, Frame_Tick, Ch_W, e.st, e.en, e.rdy, e.ft, e.chw);
      end
    end
  endtask

  task automatic wait_tick(input string tag);
    int unsigned n = 0;
    while (Frame_Tick !== 1'b1 && n < 3 * FRAME_CYC) begin
      @(negedge CLK);
      n++;
    end
    vectors++;
    assert (Frame_Tick === 1'b1) else begin
      miscompares++;
      $error("FAIL %s: got no Frame_Tick after %0d cycles, expected one within %0d", tag, n, 3 * FRAME_CYC);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    bank_t zero, min_b, armed_b, b2, b3, fs_b;
    int unsigned n;
    zero = '0;
    for (int i = 0; i < NUM_CH; i++) min_b[i] = 16'd1000;
    armed_b = '0; armed_b[0] = 16'd1500;
    b2 = armed_b; b2[3] = 16'd1000; b2[4] = 16'd2000;
    b3 = b2; b3[6] = 16'd1800;
    fs_b = '0; fs_b[0] = 16'd1000; fs_b[3] = 16'd1000; fs_b[4] = 16'd1000;

    repeat (2) @(negedge CLK);
    push("reset", 2'b00, 1'b0, 1'b1, 1'b0, zero); pop_check();
    RSTn = 1'b1;
    @(negedge CLK);

    // Write + commit while disarmed
    Wr_Valid = 1'b1; Wr_Ch = 3'd0; Wr_Data = 16'd1500;
    @(negedge CLK); Wr_Valid = 1'b0; Commit = 1'b1;
    @(negedge CLK); Commit = 1'b0;
    push("dis_commit_pending", 2'b00, 1'b0, 1'b0, 1'b0, zero); pop_check();
    @(negedge CLK);
    push("dis_commit_done", 2'b00, 1'b0, 1'b1, 1'b0, zero); pop_check();

    // Arming: MIN_US for ARMF frames, then ARMED with committed bank
    Arm_Req = 1'b1; @(negedge CLK); Arm_Req = 1'b0;
    push("arming_entry", 2'b01, 1'b1, 1'b1, 1'b0, min_b); pop_check();
    for (int k = 0; k < int'(ARMF); k++) begin
      wait_tick("arm_tick");
      push("arming_pre_tick", 2'b01, 1'b1, 1'b1, 1'b1, min_b); pop_check();
      @(negedge CLK);
      if (k == int'(ARMF) - 1) push("armed_entry", 2'b10, 1'b1, 1'b1, 1'b0, armed_b);
      else                     push("arming_post_tick", 2'b01, 1'b1, 1'b1, 1'b0, min_b);
      pop_check();
    end

    // Clamped writes and mid-frame commit in ARMED; stalled write during pending
    Wr_Valid = 1'b1; Wr_Ch = 3'd3; Wr_Data = 16'd500;
    @(negedge CLK); Wr_Ch = 3'd4; Wr_Data = 16'd2600;
    @(negedge CLK); Wr_Ch = 3'd5; Wr_Data = 16'd0;
    @(negedge CLK); Wr_Valid = 1'b0; Commit = 1'b1;
    @(negedge CLK); Commit = 1'b0;
    Wr_Valid = 1'b1; Wr_Ch = 3'd6; Wr_Data = 16'd1800;
    push("armed_commit_pending", 2'b10, 1'b1, 1'b0, 1'b0, armed_b); pop_check();
    push("armed_new_bank", 2'b10, 1'b1, 1'b1, 1'b0, b2);
    n = 0;
    while (Wr_Ready !== 1'b1 && n < 3 * FRAME_CYC) begin
      @(negedge CLK);
      n++;
    end
    pop_check();
    @(negedge CLK); Wr_Valid = 1'b0;

    // Timeout into FAILSAFE
    wait_tick("t2"); @(negedge CLK);
    push("armed_t2", 2'b10, 1'b1, 1'b1, 1'b0, b2); pop_check();
    wait_tick("t3"); @(negedge CLK);
    push("failsafe_entry", 2'b11, 1'b1, 1'b1, 1'b0, fs_b); pop_check();

    // Commit recovers to ARMED on the transfer tick
    Commit = 1'b1; @(negedge CLK); Commit = 1'b0;
    push("fs_pending", 2'b11, 1'b1, 1'b0, 1'b0, fs_b); pop_check();
    wait_tick("fs_tick");
    push("fs_pre_tick", 2'b11, 1'b1, 1'b0, 1'b1, fs_b); pop_check();
    @(negedge CLK);
    push("fs_recover", 2'b10, 1'b1, 1'b1, 1'b0, b3); pop_check();

    // Disarm wins over simultaneous Arm, mid-frame
    repeat (5) @(negedge CLK);
    Disarm_Req = 1'b1; Arm_Req = 1'b1;
    @(negedge CLK); Disarm_Req = 1'b0; Arm_Req = 1'b0;
    push("disarm_priority", 2'b00, 1'b0, 1'b1, 1'b0, zero); pop_check();

    // Asynchronous reset mid-frame with a pending commit
    Arm_Req = 1'b1; @(negedge CLK); Arm_Req = 1'b0;
    push("rearm", 2'b01, 1'b1, 1'b1, 1'b0, min_b); pop_check();
    repeat (3) @(negedge CLK);
    Wr_Valid = 1'b1; Wr_Ch = 3'd1; Wr_Data = 16'd1200; Commit = 1'b1;
    @(negedge CLK); Wr_Valid = 1'b0; Commit = 1'b0;
    push("rearm_pending", 2'b01, 1'b1, 1'b0, 1'b0, min_b); pop_check();
    #2 RSTn = 1'b0;
    #1;
    push("async_reset", 2'b00, 1'b0, 1'b1, 1'b0, zero); pop_check();
    @(negedge CLK); RSTn = 1'b1;
    @(negedge CLK);
    push("post_reset_idle", 2'b00, 1'b0, 1'b1, 1'b0, zero); pop_check();
    Arm_Req = 1'b1; @(negedge CLK); Arm_Req = 1'b0;
    for (int k = 0; k < int'(ARMF); k++) begin
      wait_tick("post_reset_arm");
      @(negedge CLK);
    end
    push("post_reset_armed", 2'b10, 1'b1, 1'b1, 1'b0, zero); pop_check();

    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL sb_leftover: got %0d queued expectations, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
